sin_nco: RTL and testbench

Parametrised numerically controlled oscillator that generates a full-wave, signed, two's-complement sine from a phase accumulator and a quarter-wave lookup table. It is the next generation of the fixed 8-bit quarter-wave sine table. It adds configurable widths, quadrant folding to the full 0..2π range, a per-cycle frequency word, phase preload and a valid-tagged pipeline. It feeds the waveform/DAC path and any block needing a sampled sine at a programmable rate.

---
 rtl/sin_nco_pkg.sv | 36 +++
 rtl/sin_nco_rom.sv | 28 ++
 rtl/sin_nco.sv | 150 +++++++++++++++
 tb/tb_sin_nco.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sin_nco_pkg.sv
// Shared types and elaboration-time helpers for the sine NCO.
// Quarter-wave table contents are computed here, so no memory file is needed.
package sin_nco_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    localparam real PI = 3.14159265358979323846;

    // Half-step offset keeps the mirrored quadrants bit-exact.
    function automatic int quarter_sin(
        input int k,
        input int addr_w,
        input int data_w
    );
        real peak;
        real x;
        peak = real'((1 << (data_w - 1)) - 1);
        x = PI / 2.0 * (real'(k) + 0.5);
        x = peak * $sin(x / real'(1 << addr_w));
        return $rtoi(x + 0.5);
    endfunction

    function automatic bit params_ok(
        input int phase_w,
        input int addr_w,
        input int data_w
    );
        return (phase_w >= addr_w + 2) && (data_w >= 2);
    endfunction

endpackage

// File: rtl/sin_nco_rom.sv
// Synchronous-read quarter-wave magnitude ROM.
// The table is built at elaboration from sin_nco_pkg::quarter_sin.
module sin_quarter_rom
    import sin_nco_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-2:0] mag
);

    localparam int MAG_W = DATA_W - 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
        localparam int V = quarter_sin(k, ADDR_W, DATA_W);
        assign rom[k] = MAG_W'(V);
    end

    always_ff @(posedge clk) begin
        mag <= rom[addr];
    end

endmodule

// File: rtl/sin_nco.sv
// Phase-accumulator sine NCO with quadrant folding and a 2-stage pipeline.
// Define SIN_NCO_COS_EN to add the aligned cos_out output.
module sin_nco
    import sin_nco_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               phase_load,
    input  logic [PHASE_W-1:0] phase_in,
    output logic               out_valid,
    output logic [DATA_W-1:0]  sin_out
`ifdef SIN_NCO_COS_EN
    ,
    output logic [DATA_W-1:0]  cos_out
`endif
);

    localparam int MAG_W = DATA_W - 1;

    if (!params_ok(PHASE_W, ADDR_W, DATA_W)) begin : g_bad_params
        $error("sin_nco: need PHASE_W >= ADDR_W+2 and DATA_W >= 2");
    end

    function automatic logic [DATA_W-1:0] apply_sign(
        input logic [MAG_W-1:0] m,
        input logic             neg
    );
        logic [DATA_W-1:0] v;
        v = {1'b0, m};
        return neg ? -v : v;
    endfunction

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               issue;
    quad_e              s_quad;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  s_addr;
    logic               s_neg;
    logic [MAG_W-1:0]   s_mag;
    logic               s_neg1_q;
    logic               vld1_q, vld2_q;
    logic [DATA_W-1:0]  sin_q, sin_d;

    assign issue  = en & ~phase_load;
    assign s_quad = quad_e'(phase_q[PHASE_W-1 -: 2]);
    assign idx    = phase_q[PHASE_W-3 -: ADDR_W];

    always_comb begin
        phase_d = phase_q;
        if (phase_load) begin
            phase_d = phase_in;
        end else if (en) begin
            phase_d = phase_q + freq_word;
        end
    end

    always_comb begin
        s_addr = idx;
        s_neg  = 1'b0;
        unique case (s_quad)
            Q0: begin s_addr = idx;  s_neg = 1'b0; end
            Q1: begin s_addr = ~idx; s_neg = 1'b0; end
            Q2: begin s_addr = idx;  s_neg = 1'b1; end
            Q3: begin s_addr = ~idx; s_neg = 1'b1; end
        endcase
    end

    sin_quarter_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom_sin (
        .clk  (clk),
        .addr (s_addr),
        .mag  (s_mag)
    );

    assign sin_d = vld1_q ? apply_sign(s_mag, s_neg1_q) : sin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
            s_neg1_q <= 1'b0;
            sin_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            vld1_q   <= issue;
            vld2_q   <= vld1_q;
            s_neg1_q <= s_neg;
            sin_q    <= sin_d;
        end
    end

    assign out_valid = vld2_q;
    assign sin_out   = sin_q;

`ifdef SIN_NCO_COS_EN
    // Cosine is the same index one quadrant ahead.
    quad_e              c_quad;
    logic [ADDR_W-1:0]  c_addr;
    logic               c_neg;
    logic [MAG_W-1:0]   c_mag;
    logic               c_neg1_q;
    logic [DATA_W-1:0]  cos_q, cos_d;

    assign c_quad = quad_e'(2'(s_quad + 2'd1));

    always_comb begin
        c_addr = idx;
        c_neg  = 1'b0;
        unique case (c_quad)
            Q0: begin c_addr = idx;  c_neg = 1'b0; end
            Q1: begin c_addr = ~idx; c_neg = 1'b0; end
            Q2: begin c_addr = idx;  c_neg = 1'b1; end
            Q3: begin c_addr = ~idx; c_neg = 1'b1; end
        endcase
    end

    sin_quarter_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom_cos (
        .clk  (clk),
        .addr (c_addr),
        .mag  (c_mag)
    );

    assign cos_d = vld1_q ? apply_sign(c_mag, c_neg1_q) : cos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_neg1_q <= 1'b0;
            cos_q    <= '0;
        end else begin
            c_neg1_q <= c_neg;
            cos_q    <= cos_d;
        end
    end

    assign cos_out = cos_q;
`endif

endmodule

// File: tb/tb_sin_nco.sv
// Scoreboard bench for sin_nco: randomized and directed stimulus
// checked against an angle-based sine model.
module tb_sin_nco;

    localparam int PW   = 16;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam real PK  = 127.0;
    localparam real PI2 = 6.28318530717958647692;
    localparam int NOEXP = 9999;

    typedef struct {
        int e;
        int s;
        int c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] freq_word = '0;
    logic          phase_load = 1'b0;
    logic [PW-1:0] phase_in = '0;
    logic          out_valid;
    logic [DW-1:0] sin_out;
`ifdef SIN_NCO_COS_EN
    logic [DW-1:0] cos_out;
`endif

    exp_t          sbq[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            edge_n = 0;
    int            last_s = 0;
    int            last_c = 0;
    logic [PW-1:0] mph = '0;

    sin_nco #(
        .PHASE_W (PW),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .freq_word  (freq_word),
        .phase_load (phase_load),
        .phase_in   (phase_in),
        .out_valid  (out_valid),
        .sin_out    (sin_out)
`ifdef SIN_NCO_COS_EN
        ,
        .cos_out    (cos_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    // Sine at the centre of the quantised angle bin, rounded half away from 0.
    function automatic int ref_wave(input logic [PW-1:0] p, input bit cosine);
        int  n;
        int  m;
        real th;
        real s;
        n  = int'(p >> (PW - AW - 2));
        th = PI2 * (real'(n) + 0.5) / real'(4 << AW);
        s  = cosine ? $cos(th) : $sin(th);
        m  = $rtoi(PK * (s < 0.0 ? -s : s) + 0.5);
        return (s < 0.0) ? -m : m;
    endfunction

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    task automatic step(
        input bit            e,
        input bit            ld,
        input logic [PW-1:0] fw,
        input logic [PW-1:0] pin,
        input int            force_s
    );
        exp_t x;
        @(negedge clk);
        en         = e;
        phase_load = ld;
        freq_word  = fw;
        phase_in   = pin;
        if (ld) begin
            mph = pin;
        end else if (e) begin
            x.e = edge_n + 2;
            x.s = (force_s == NOEXP) ? ref_wave(mph, 1'b0) : force_s;
            x.c = ref_wave(mph, 1'b1);
            sbq.push_back(x);
            mph = mph + fw;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, NOEXP);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (rst_n) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    x = sbq.pop_front();
                    check("latency_edge", edge_n, x.e);
                    check("sin_out", int'($signed(sin_out)), x.s);
                    last_s = x.s;
`ifdef SIN_NCO_COS_EN
                    check("cos_out", int'($signed(cos_out)), x.c);
                    last_c = x.c;
`endif
                end
            end else begin
                check("sin_hold", int'($signed(sin_out)), last_s);
`ifdef SIN_NCO_COS_EN
                check("cos_hold", int'($signed(cos_out)), last_c);
`endif
                if (sbq.size() > 0 && sbq[0].e <= edge_n) begin
                    x = sbq.pop_front();
                    check("missing_valid_at_edge", 0, x.e);
                end
            end
        end
    end

    initial begin
        logic [PW-1:0] qpts [5];
        int            qexp [5];
        qpts = '{16'h0000, 16'h2000, 16'h4000, 16'h8000, 16'hC000};
        qexp = '{0, 90, 127, 0, -127};

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_sin", int'($signed(sin_out)), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First sample after reset comes from phase 0.
        step(1'b1, 1'b0, 16'h0000, '0, 0);
        idle(3);

        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, '0, qpts[k], NOEXP);
            step(1'b1, 1'b0, '0, '0, qexp[k]);
            idle(2);
        end

        step(1'b0, 1'b1, '0, 16'h0000, NOEXP);
        for (int k = 0; k < 70; k++) begin
            step(1'b1, 1'b0, 16'h0400, '0, NOEXP);
        end
        idle(3);

        step(1'b1, 1'b0, 16'h0800, '0, NOEXP);
        step(1'b0, 1'b0, 16'h0800, '0, NOEXP);
        step(1'b1, 1'b0, 16'h0800, '0, NOEXP);
        step(1'b1, 1'b1, 16'h1234, 16'h3000, NOEXP);
        step(1'b1, 1'b0, 16'h0100, '0, NOEXP);
        idle(3);

        step(1'b0, 1'b1, '0, 16'hFF00, NOEXP);
        step(1'b1, 1'b0, 16'h0200, '0, NOEXP);
        step(1'b1, 1'b0, 16'h0200, '0, NOEXP);
        idle(3);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 1) != 0) ? PW'($urandom)
                                             : PW'($urandom_range(0, 2047)),
                 PW'($urandom), NOEXP);
        end
        idle(3);

        // Asynchronous reset with a full pipeline and en held high.
        step(1'b0, 1'b1, '0, 16'h1000, NOEXP);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 16'h0500, '0, NOEXP);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_sin", int'($signed(sin_out)), 0);
`ifdef SIN_NCO_COS_EN
        check("async_rst_cos", int'($signed(cos_out)), 0);
`endif
        sbq.delete();
        mph    = '0;
        last_s = 0;
        last_c = 0;
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h4000, '0, 0);
        step(1'b1, 1'b0, 16'h4000, '0, 127);
        idle(4);

        check("queue_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
